// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator key sequencer.
// Holds the FSM state enum, the latched operation/operand payload struct,
// and helpers for key priority and operation pattern encoding.
package calc_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned KEY_W  = 3;

    // No operation selected: all active-low key bits released.
    localparam logic [KEY_W-1:0] OP_NONE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    // Payload handed to the calculator: key pattern plus both operands.
    typedef struct packed {
        logic [KEY_W-1:0]  op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } calc_word_t;

    // Lowest pressed index wins: KEY[0] over KEY[1] over KEY[2].
    function automatic logic [1:0] first_pressed(input logic [KEY_W-1:0] p);
        if (p[0]) begin
            return 2'd0;
        end else if (p[1]) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    // Active-low pattern with only bit idx low.
    function automatic logic [KEY_W-1:0] op_pattern(input logic [1:0] idx);
        return ~(KEY_W'(1) << idx);
    endfunction

endpackage

// File: rtl/calc_sync2.sv
// Two-flop synchroniser with configurable width and reset value.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised output).
module calc_sync2 #(
    parameter int unsigned     W       = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Input stage for the 4-bit calculator: synchronises and debounces the three
// active-low push-buttons, latches OP/A/B on each accepted press and pulses
// VALID one cycle after the latch.
// Ports:
//   CLOCK_50  system clock
//   RESET_N   asynchronous active-low reset
//   KEY[2:0]  raw active-low buttons
//   SW[7:0]   raw switches, SW[7:4]=A, SW[3:0]=B
//   OP[2:0]   latched active-low key pattern
//   A, B      latched operands
//   VALID     one-cycle strobe after an OP/A/B update
//   BUSY      high while a press is debounced or held
// Optional: define CALC_AUTO_REPEAT_EN to resample A/B every REPEAT_CYCLES
// while the key stays held.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned      CNT_W           = 16,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(50000),
    parameter logic [CNT_W-1:0] REPEAT_CYCLES   = CNT_W'(25000)
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [KEY_W-1:0]  KEY,
    input  logic [7:0]        SW,
    output logic [KEY_W-1:0]  OP,
    output logic [OPND_W-1:0] A,
    output logic [OPND_W-1:0] B,
    output logic              VALID,
    output logic              BUSY
);

    localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CYCLES - CNT_W'(1);

    logic [KEY_W-1:0] k_s;
    logic [7:0]       sw_s;
    logic [KEY_W-1:0] p;
    logic             c_pressed;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       key_idx_q, key_idx_d;
    calc_word_t       word_q, word_d;
    logic             fresh_q, fresh_d;

    // Input synchronisers: keys reset to released, switches to zero.
    calc_sync2 #(.W(KEY_W), .RST_VAL({KEY_W{1'b1}})) u_sync_key (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .d     (KEY),
        .q     (k_s)
    );

    calc_sync2 #(.W(8), .RST_VAL(8'h00)) u_sync_sw (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .d     (SW),
        .q     (sw_s)
    );

    assign p         = ~k_s;
    assign c_pressed = p[key_idx_q];

`ifdef CALC_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RP_LAST = REPEAT_CYCLES - CNT_W'(1);
    logic [CNT_W-1:0] rpt_q, rpt_d;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
`endif

    // Next-state and payload logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_idx_d = key_idx_q;
        word_d    = word_q;
        fresh_d   = 1'b0;
`ifdef CALC_AUTO_REPEAT_EN
        rpt_d     = rpt_q;
`endif
        case (state_q)
            IDLE: begin
                if (p != '0) begin
                    key_idx_d = first_pressed(p);
                    cnt_d     = '0;
                    state_d   = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!c_pressed) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    word_d.op = op_pattern(key_idx_q);
                    word_d.a  = sw_s[7:4];
                    word_d.b  = sw_s[3:0];
                    fresh_d   = 1'b1;
                    state_d   = HELD;
`ifdef CALC_AUTO_REPEAT_EN
                    rpt_d     = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!c_pressed) begin
                    cnt_d   = '0;
                    state_d = REL_DB;
                end else begin
`ifdef CALC_AUTO_REPEAT_EN
                    // Resample operands periodically; OP stays as captured.
                    if (rpt_q == RP_LAST) begin
                        rpt_d    = '0;
                        word_d.a = sw_s[7:4];
                        word_d.b = sw_s[3:0];
                        fresh_d  = 1'b1;
                    end else begin
                        rpt_d = rpt_q + CNT_W'(1);
                    end
`endif
                end
            end
            REL_DB: begin
                if (c_pressed) begin
                    // Release bounce: resume hold without a new capture.
                    state_d = HELD;
`ifdef CALC_AUTO_REPEAT_EN
                    rpt_d   = '0;
`endif
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_idx_q <= '0;
            word_q    <= '{op: OP_NONE, a: '0, b: '0};
            fresh_q   <= 1'b0;
            VALID     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_idx_q <= key_idx_d;
            word_q    <= word_d;
            fresh_q   <= fresh_d;
            VALID     <= fresh_q;
            BUSY      <= (state_d != IDLE);
        end
    end

    assign OP = word_q.op;
    assign A  = word_q.a;
    assign B  = word_q.b;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Expected captures are queued as stimulus is driven and popped by a
// monitor on each VALID pulse.
module tb_calc_key_sequencer;
    import calc_pkg::*;

    localparam logic [15:0] DB = 16'd4;
    localparam logic [15:0] RP = 16'd8;
`ifdef CALC_AUTO_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        key;
    logic [7:0]        sw;
    logic [2:0]        op;
    logic [3:0]        a;
    logic [3:0]        b;
    logic              valid;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    calc_word_t exp_q[$];

    calc_key_sequencer #(
        .CNT_W           (16),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .KEY      (key),
        .SW       (sw),
        .OP       (op),
        .A        (a),
        .B        (b),
        .VALID    (valid),
        .BUSY     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs settle after the rising edge; sample and drive just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] eo, input logic [3:0] ea, input logic [3:0] eb);
        calc_word_t w;
        w.op = eo;
        w.a  = ea;
        w.b  = eb;
        exp_q.push_back(w);
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int k = 0;
        while (busy && k < max_cycles) begin
            tick();
            k++;
        end
        chk(tag, 32'(busy), 32'(0));
    endtask

    // Scoreboard: every VALID must match the oldest queued capture.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(1), 32'(0));
            end else begin
                calc_word_t e;
                e = exp_q.pop_front();
                chk("sb_op", 32'(op), 32'(e.op));
                chk("sb_a",  32'(a),  32'(e.a));
                chk("sb_b",  32'(b),  32'(e.b));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic exp_v;
        logic [3:0] ea, eb;

        // Reset held with a key pressed and switches set.
        rst_n = 1'b0;
        key   = 3'b010;
        sw    = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_op",    32'(op),    32'(3'b111));
            chk("rst_a",     32'(a),     32'(0));
            chk("rst_b",     32'(b),     32'(0));
            chk("rst_valid", 32'(valid), 32'(0));
            chk("rst_busy",  32'(busy),  32'(0));
        end
        key   = 3'b111;
        rst_n = 1'b1;
        repeat (4) tick();

        // Clean press of KEY[1]: latch at edge 7, VALID at edge 8.
        sw  = 8'h3E;
        key = 3'b101;
        push_exp(3'b101, 4'h3, 4'hE);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("clean_valid", 32'(valid), 32'(i == 8));
            chk("clean_busy",  32'(busy),  32'(i >= 3));
            if (i == 6) chk("clean_op_old", 32'(op), 32'(3'b111));
            if (i == 7) chk("clean_op_new", 32'(op), 32'(3'b101));
        end
        key = 3'b111;
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("release_busy", 32'(busy), 32'(j < 7));
        end

        // Bouncy press of KEY[0]: exactly one capture.
        sw = 8'h5C;
        repeat (3) tick();
        n0 = n_valid;
        push_exp(3'b110, 4'h5, 4'hC);
        key = 3'b110;
        repeat (2) tick();
        key = 3'b111;
        tick();
        key = 3'b110;
        repeat (10) tick();
        key = 3'b111;
        wait_idle("bounce_idle", 20);
        chk("bounce_count", 32'(n_valid - n0), 32'(1));
        chk("bounce_op",    32'(op), 32'(3'b110));

        // Switch change alone and a short glitch on KEY[2]: no effect.
        sw = 8'hFF;
        repeat (5) tick();
        chk("sw_only_a", 32'(a), 32'(4'h5));
        chk("sw_only_b", 32'(b), 32'(4'hC));
        n0 = n_valid;
        key = 3'b011;
        repeat (2) tick();
        key = 3'b111;
        repeat (10) tick();
        wait_idle("glitch_idle", 20);
        chk("glitch_count", 32'(n_valid - n0), 32'(0));
        chk("glitch_op",    32'(op), 32'(3'b110));

        // All keys together: KEY[0] wins; other keys and SW ignored while held.
        sw = 8'h9A;
        n0 = n_valid;
        push_exp(3'b110, 4'h9, 4'hA);
        key = 3'b000;
        repeat (12) tick();
        chk("prio_count", 32'(n_valid - n0), 32'(1));
        chk("prio_op",    32'(op), 32'(3'b110));
        n0 = n_valid;
        key = 3'b010;
        sw  = 8'h12;
        repeat (6) tick();
        key = 3'b000;
        repeat (6) tick();
        chk("ignore_count", 32'(n_valid - n0), 32'(0));
        chk("ignore_a",     32'(a), 32'(4'h9));
        chk("ignore_b",     32'(b), 32'(4'hA));
        key = 3'b111;
        wait_idle("prio_idle", 20);

        // Reset two cycles into PRESS_DB, key held through reset release.
        sw = 8'h47;
        repeat (3) tick();
        key = 3'b101;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_op",    32'(op),    32'(3'b111));
        chk("midrst_a",     32'(a),     32'(0));
        chk("midrst_b",     32'(b),     32'(0));
        chk("midrst_valid", 32'(valid), 32'(0));
        chk("midrst_busy",  32'(busy),  32'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        push_exp(3'b101, 4'h4, 4'h7);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("midrst_valid_post", 32'(valid), 32'(i == 8));
        end
        key = 3'b111;
        wait_idle("midrst_idle", 20);

        // Long hold of KEY[2] with a switch change mid-hold.
        sw = 8'h2B;
        repeat (3) tick();
        for (int i = 1; i <= 52; i++) begin
            exp_v = (i == 8) || (RPT_EN && i > 8 && (i % 8) == 0);
            if (exp_v) begin
                ea = (i >= 24) ? 4'h7 : 4'h2;
                eb = (i >= 24) ? 4'h1 : 4'hB;
                push_exp(3'b011, ea, eb);
            end
        end
        n0 = n_valid;
        key = 3'b011;
        for (int i = 1; i <= 52; i++) begin
            tick();
            exp_v = (i == 8) || (RPT_EN && i > 8 && (i % 8) == 0);
            chk("hold_valid", 32'(valid), 32'(exp_v));
            if (i == 18) sw = 8'h71;
            if (i == 47) key = 3'b111;
        end
        wait_idle("hold_idle", 20);
        chk("hold_op", 32'(op), 32'(3'b011));
        chk("hold_a",  32'(a),  RPT_EN ? 32'(4'h7) : 32'(4'h2));
        chk("hold_b",  32'(b),  RPT_EN ? 32'(4'h1) : 32'(4'hB));
        chk("hold_count", 32'(n_valid - n0), RPT_EN ? 32'(6) : 32'(1));

        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
